// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory among NUM_REQ requesters; accept -> strobe next cycle -> rsp one cycle after mem_response.
// Requesters hold req_valid until the req_ready pulse; the ARB_TIMEOUT_EN macro adds an abort after TIMEOUT strobe cycles.
module mem_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      mem_wr,
  output logic                      mem_rd,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_response
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic               mem_wr_q, mem_wr_d;
  logic               mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [NUM_REQ-1:0] ready_c;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_err_q, rsp_err_d;
`endif

  // Rotate the request vector so bit 0 is the requester at the pointer.
  logic [SUM_W-1:0]   rot_shamt;
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   gnt_off;
  logic [SUM_W-1:0]   gnt_sum;
  logic [IDX_W-1:0]   gnt_idx;
  logic               sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [SUM_W-1:0]   g_inc;
  logic [IDX_W-1:0]   ptr_nxt;

  assign rot_shamt = SUM_W'(NUM_REQ) - {1'b0, ptr_q};
  assign rot       = (req_valid >> ptr_q) | (req_valid << rot_shamt);

  always_comb begin
    gnt_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) gnt_off = IDX_W'(i);
    end
  end

  assign gnt_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
  assign gnt_idx = (gnt_sum >= SUM_W'(NUM_REQ)) ? IDX_W'(gnt_sum - SUM_W'(NUM_REQ))
                                                : IDX_W'(gnt_sum);

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign g_inc   = {1'b0, g_q} + SUM_W'(1);
  assign ptr_nxt = (g_inc == SUM_W'(NUM_REQ)) ? '0 : IDX_W'(g_inc);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    mem_wr_d    = mem_wr_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    ready_c     = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          ready_c     = NUM_REQ'(1) << gnt_idx;
          g_d         = gnt_idx;
          mem_wr_d    = sel_wr;
          mem_rd_d    = ~sel_wr;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          state_d     = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUSY: begin
        if (mem_response) begin
          mem_wr_d    = 1'b0;
          mem_rd_d    = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << g_q;
          rsp_rdata_d = mem_wr_q ? '0 : mem_rdata;
          state_d     = DONE;
`ifdef ARB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Memory never answered: abort and report an error to the owner.
          mem_wr_d    = 1'b0;
          mem_rd_d    = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << g_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
`endif
        end
      end
      DONE: begin
        ptr_d   = ptr_nxt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // The only combinational output; forced low while reset is held.
  assign req_ready = reset ? ready_c : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_wr    = mem_wr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef ARB_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
